div: RTL and testbench

// Multi-cycle 32-bit radix-2 restoring divider FSM serving the EX stage's div/divu
// ({hi,lo} <- rs/rt). EX holds div_start_i and its own stall request high until
// div_ready_o == `DivResultReady. It then writes {hi,lo} from div_result_o.
// One request in flight at a time. div_annul_i aborts the current request on a pipeline flush.

---
 rtl/div.sv | 128 ++++++++++++
 tb/tb_div.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/div.sv
// div: multi-cycle radix-2 restoring divider for the EX stage div/divu.
// One request at a time; EX holds div_start_i high until div_ready_o is seen,
// then writes {hi, lo} from div_result_o.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   div_signed_i      1 = signed (div), 0 = unsigned (divu)
//   div_op1_i         dividend (rs)
//   div_op2_i         divisor (rt)
//   div_start_i       request, held high until ready is seen
//   div_annul_i       abort the current division (pipeline flush)
//   div_result_o      {remainder, quotient} -> {hi, lo}
//   div_ready_o       div_result_o valid
module div #(
  parameter int unsigned DIV_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 div_signed_i,
  input  logic [DIV_W-1:0]     div_op1_i,
  input  logic [DIV_W-1:0]     div_op2_i,
  input  logic                 div_start_i,
  input  logic                 div_annul_i,
  output logic [2*DIV_W-1:0]   div_result_o,
  output logic                 div_ready_o
);

  localparam int unsigned CNT_W = $clog2(DIV_W + 1);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*DIV_W:0]   dividend;
  logic [DIV_W-1:0]   divisor;
  logic               sign1;
  logic               sign2;
  logic               signed_q;

  logic [DIV_W-1:0]   op1_mag;
  logic [DIV_W-1:0]   op2_mag;
  logic [DIV_W:0]     tmp;
  logic [DIV_W-1:0]   q_fin;
  logic [DIV_W-1:0]   r_fin;

  always_comb begin
    op1_mag = (div_signed_i && div_op1_i[DIV_W-1]) ? -div_op1_i : div_op1_i;
    op2_mag = (div_signed_i && div_op2_i[DIV_W-1]) ? -div_op2_i : div_op2_i;
    // Trial subtraction; tmp[DIV_W] set means the divisor did not fit (borrow).
    tmp     = {1'b0, dividend[2*DIV_W-1:DIV_W]} - {1'b0, divisor};
    q_fin   = dividend[DIV_W-1:0];
    r_fin   = dividend[2*DIV_W:DIV_W+1];
    if (signed_q && (sign1 != sign2)) q_fin = -dividend[DIV_W-1:0];
    // Remainder takes the sign of the dividend.
    if (signed_q && sign1)            r_fin = -dividend[2*DIV_W:DIV_W+1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_FREE;
      cnt          <= '0;
      dividend     <= '0;
      divisor      <= '0;
      sign1        <= 1'b0;
      sign2        <= 1'b0;
      signed_q     <= 1'b0;
      div_result_o <= '0;
      div_ready_o  <= 1'b0;
    end else begin
      case (state)
        ST_FREE: begin
          div_result_o <= '0;
          div_ready_o  <= 1'b0;
          if (div_start_i && !div_annul_i) begin
            if (div_op2_i == '0) begin
              state <= ST_BYZERO;
            end else begin
              state    <= ST_ON;
              cnt      <= '0;
              dividend <= {{DIV_W{1'b0}}, op1_mag, 1'b0};
              divisor  <= op2_mag;
              sign1    <= div_op1_i[DIV_W-1];
              sign2    <= div_op2_i[DIV_W-1];
              signed_q <= div_signed_i;
            end
          end
        end
        ST_BYZERO: begin
          state        <= ST_END;
          div_result_o <= '0;
          div_ready_o  <= 1'b1;
        end
        ST_ON: begin
          if (div_annul_i) begin
            state        <= ST_FREE;
            div_result_o <= '0;
            div_ready_o  <= 1'b0;
          end else if (cnt != CNT_W'(DIV_W)) begin
            if (tmp[DIV_W]) dividend <= dividend << 1;
            else            dividend <= {tmp[DIV_W-1:0], dividend[DIV_W-1:0], 1'b1};
            cnt <= cnt + CNT_W'(1);
          end else begin
            state        <= ST_END;
            div_result_o <= {r_fin, q_fin};
            div_ready_o  <= 1'b1;
          end
        end
        ST_END: begin
          if (!div_start_i || div_annul_i) begin
            state        <= ST_FREE;
            div_result_o <= '0;
            div_ready_o  <= 1'b0;
          end
        end
        default: begin
          state        <= ST_FREE;
          div_result_o <= '0;
          div_ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// tb_div: randomized and directed checks of div against a plain-arithmetic model.
module tb_div;

  logic        clk;
  logic        rst;
  logic        div_signed;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int errors = 0;
  int checks = 0;

  div #(.DIV_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_signed_i (div_signed),
    .div_op1_i    (op1),
    .div_op2_i    (op2),
    .div_start_i  (start),
    .div_annul_i  (annul),
    .div_result_o (result),
    .div_ready_o  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {remainder, quotient} from magnitudes and sign rules; zero divisor gives 0.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return 64'd0;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (sgn && (a[31] != b[31])) q = -q;
    if (sgn && a[31])            r = -r;
    return {r, q};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge in FREE. lat counts edges including the start edge.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, input int hold, input string tag,
                         output logic [63:0] res);
    int          lat;
    bit          seen;
    logic [63:0] exp;
    exp        = ref_div(sgn, a, b);
    div_signed = sgn;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    lat        = 0;
    seen       = 1'b0;
    while (!seen && lat < 100) begin
      tick();
      lat++;
      if (scramble && lat == 5) begin
        op1        = $urandom;
        op2        = $urandom;
        div_signed = ~sgn;
      end
      if (ready) seen = 1'b1;
    end
    check({tag, "_ready_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd34);
    res = result;
    check({tag, "_result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_ready"}, 64'(ready), 64'd1);
      check({tag, "_hold_result"}, result, exp);
    end
    start = 1'b0;
    tick();
    check({tag, "_drop_ready"}, 64'(ready), 64'd0);
    check({tag, "_drop_result"}, result, 64'd0);
  endtask

  logic [63:0] res;
  logic [31:0] ra, rb;
  logic        rs;
  bit          saw_ready;

  initial begin
    rst = 1'b1; div_signed = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
    repeat (3) tick();
    check("reset_result", result, 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    rst = 1'b0;
    tick();

    run_div(1'b0, 32'd100, 32'd7, 1'b0, 3, "udiv_100_7", res);
    check("udiv_100_7_const", res, {32'd2, 32'd14});
    run_div(1'b1, -32'sd7, 32'd2, 1'b0, 0, "sdiv_m7_2", res);
    check("sdiv_m7_2_const", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div(1'b1, 32'd7, -32'sd2, 1'b0, 0, "sdiv_7_m2", res);
    check("sdiv_7_m2_const", res, {32'h0000_0001, 32'hFFFF_FFFD});
    run_div(1'b1, 32'd55, 32'd0, 1'b0, 1, "sdiv_by0", res);
    run_div(1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0, 0, "udiv_by0", res);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "sdiv_ovf", res);
    check("sdiv_ovf_const", res, {32'd0, 32'h8000_0000});
    run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "udiv_ovf", res);
    check("udiv_ovf_const", res, {32'h8000_0000, 32'd0});

    // Annul at E10: back to FREE with nothing reported, then an immediate restart.
    div_signed = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    saw_ready = 1'b0;
    repeat (10) begin
      tick();
      if (ready) saw_ready = 1'b1;
    end
    annul = 1'b1;
    tick();
    annul = 1'b0;
    start = 1'b0;
    check("annul_ready", 64'(ready | saw_ready), 64'd0);
    check("annul_result", result, 64'd0);
    run_div(1'b0, 32'd1000, 32'd3, 1'b0, 0, "after_annul", res);

    // Reset in the middle of an iteration run.
    div_signed = 1'b1; op1 = 32'd12345; op2 = 32'd17; start = 1'b1;
    repeat (15) tick();
    rst = 1'b1;
    tick();
    check("midrst_result", result, 64'd0);
    check("midrst_ready", 64'(ready), 64'd0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    run_div(1'b1, 32'd12345, 32'd17, 1'b0, 0, "after_rst", res);

    run_div(1'b0, 32'hFFFF_FFF0, 32'd9, 1'b1, 0, "scramble_u", res);
    run_div(1'b1, 32'h8765_4321, 32'hFFFF_FF03, 1'b1, 0, "scramble_s", res);

    // The datapath compares only DIV_W bits of the partial remainder, so
    // unsigned divisors are kept at or below 2^31 in the random set.
    for (int n = 0; n < 40; n++) begin
      rs = 1'(($urandom >> 3) & 1);
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      if (!rs && rb[31]) rb = 32'h8000_0000;
      run_div(rs, ra, rb, 1'b0, n % 2, "rand", res);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
